// File: rtl/cs0_bus_master_pkg.sv
// rtl/cs0_bus_master_pkg.sv - shared FSM states and CS0 address windows for the CS0 bus master
package cs0_bus_master_pkg;

    // Bus master cycle states
    typedef enum logic [2:0] {
        IDLE,
        ARB,
        T1,
        T2,
        END,
        REL
    } state_t;

    // CS0 byte-address windows; the master itself does not decode these
    localparam logic [24:0] ROM_BASE   = 25'h0000000;
    localparam logic [24:0] SMPC_BASE  = 25'h0100000;
    localparam logic [24:0] SRAM_BASE  = 25'h0180000;
    localparam logic [24:0] LWRAM_BASE = 25'h0200000;
    localparam logic [24:0] MINIT_BASE = 25'h1000000;
    localparam logic [24:0] SINIT_BASE = 25'h1800000;

    // Byte address to the word address carried on A[24:1]
    function automatic logic [23:0] word_addr(input logic [24:0] byte_addr);
        return 24'(byte_addr >> 1);
    endfunction

endpackage

// File: rtl/cs0_wait_timer.sv
// rtl/cs0_wait_timer.sv - saturating WAIT_N counter with timeout compare
//
// Ports:
//   CLK, RST_N  clock, asynchronous active-low reset
//   clr         synchronous clear (start of a bus cycle, soft reset)
//   inc         count one wait tick
//   last        high when the next counted tick reaches TIMEOUT
module cs0_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clr,
    input  logic inc,
    output logic last
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // The FSM aborts on the tick that would bring the count to TIMEOUT
    assign last = (cnt >= CNT_LAST);

endmodule

// File: rtl/cs0_bus_master.sv
// rtl/cs0_bus_master.sv - CS0 secondary bus master: EXBREQ/EXBACK arbitration and SH-2-style cycles
//
// Ports:
//   CLK, RST_N, CE_R, CE_F, RES_N          clocking, resets, rising/falling clock enables
//   REQ, REQ_WR, REQ_ADDR, REQ_BE, REQ_WDATA command port (held stable until ACK)
//   ACK, ERR, RDATA, BUSY                  completion pulse, timeout/abort flag, read data, status
//   EXBREQ_N, EXBACK_N                     bus request / grant
//   A, BS_N, CS0_N, RD_WR_N, RD_N, WE_N, DO, DI, WAIT_N   CS0 bus
module cs0_bus_master
    import cs0_bus_master_pkg::*;
#(
    parameter int TIMEOUT  = 255,
    parameter bit HOLD_BUS = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE_R,
    input  logic        CE_F,
    input  logic        RES_N,
    input  logic        REQ,
    input  logic        REQ_WR,
    input  logic [23:0] REQ_ADDR,
    input  logic [1:0]  REQ_BE,
    input  logic [15:0] REQ_WDATA,
    output logic        ACK,
    output logic        ERR,
    output logic [15:0] RDATA,
    output logic        BUSY,
    output logic        EXBREQ_N,
    input  logic        EXBACK_N,
    output logic [23:0] A,
    output logic        BS_N,
    output logic        CS0_N,
    output logic        RD_WR_N,
    output logic        RD_N,
    output logic [1:0]  WE_N,
    input  logic [15:0] DI,
    output logic [15:0] DO,
    input  logic        WAIT_N
);
    state_t      state, state_n;
    logic        cmd_wr;
    logic [23:0] cmd_addr;
    logic [1:0]  cmd_be;
    logic [15:0] cmd_wdata;
    logic        done;
    logic [15:0] rbuf;
    logic        ld_cmd, go_ack, go_err;
    logic        owned, lost, samp, done_eff;
    logic        tmr_clr, tmr_inc, tmr_last;

    assign owned    = (state == T1) || (state == T2) || (state == END);
    // Grant withdrawn while we drive the bus: leave at once, not on CE_R
    assign lost     = ((state == T1) || (state == T2)) && EXBACK_N;
    // WAIT_N sample; when CE_F and CE_R coincide this sample feeds the same transition
    assign samp     = (state == T2) && CE_F && WAIT_N && !done;
    assign done_eff = done || samp;
    assign tmr_clr  = !RES_N || (state == T1);
    assign tmr_inc  = (state == T2) && CE_R && !done_eff && !lost;

    cs0_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .CLK  (CLK),
        .RST_N(RST_N),
        .clr  (tmr_clr),
        .inc  (tmr_inc),
        .last (tmr_last)
    );

    always_comb begin
        state_n = state;
        ld_cmd  = 1'b0;
        go_ack  = 1'b0;
        go_err  = 1'b0;
        case (state)
            IDLE: begin
                if (CE_R && REQ) begin
                    ld_cmd  = 1'b1;
                    state_n = ARB;
                end
            end
            ARB: begin
                if (CE_R && !EXBACK_N) state_n = T1;
            end
            T1: begin
                if (lost) begin
                    state_n = END;
                    go_ack  = 1'b1;
                    go_err  = 1'b1;
                end else if (CE_R) begin
                    state_n = T2;
                end
            end
            T2: begin
                if (lost) begin
                    state_n = END;
                    go_ack  = 1'b1;
                    go_err  = 1'b1;
                end else if (CE_R) begin
                    if (done_eff) begin
                        state_n = END;
                        go_ack  = 1'b1;
                    end else if (tmr_last) begin
                        state_n = END;
                        go_ack  = 1'b1;
                        go_err  = 1'b1;
                    end
                end
            end
            END: begin
                if (CE_R) begin
                    if (HOLD_BUS && REQ && !EXBACK_N) begin
                        ld_cmd  = 1'b1;
                        state_n = T1;
                    end else begin
                        state_n = REL;
                    end
                end
            end
            REL: begin
                if (CE_R && EXBACK_N) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            cmd_wr    <= 1'b0;
            cmd_addr  <= '0;
            cmd_be    <= '0;
            cmd_wdata <= '0;
            done      <= 1'b0;
            rbuf      <= '0;
            ACK       <= 1'b0;
            ERR       <= 1'b0;
            RDATA     <= '0;
        end else if (!RES_N) begin
            state     <= IDLE;
            cmd_wr    <= 1'b0;
            cmd_addr  <= '0;
            cmd_be    <= '0;
            cmd_wdata <= '0;
            done      <= 1'b0;
            rbuf      <= '0;
            ACK       <= 1'b0;
            ERR       <= 1'b0;
            RDATA     <= '0;
        end else begin
            state <= state_n;
            ACK   <= go_ack;
            ERR   <= go_err;
            if (ld_cmd) begin
                cmd_wr    <= REQ_WR;
                cmd_addr  <= REQ_ADDR;
                cmd_be    <= REQ_BE;
                cmd_wdata <= REQ_WDATA;
            end
            if (state == T1) begin
                done <= 1'b0;
            end else if (samp) begin
                done <= 1'b1;
                if (!cmd_wr) rbuf <= DI;
            end
            // RDATA only changes on a successful read completion
            if (go_ack && !go_err && !cmd_wr) RDATA <= samp ? DI : rbuf;
        end
    end

    // Bus pins are decoded from state so reset and abort release them on the same edge
    assign BUSY     = (state != IDLE);
    assign EXBREQ_N = !((state == ARB) || owned);
    assign A        = owned ? cmd_addr : '0;
    assign RD_WR_N  = !(owned && cmd_wr);
    assign DO       = (owned && cmd_wr) ? cmd_wdata : '0;
    assign BS_N     = (state != T1);
    assign CS0_N    = !((state == T1) || (state == T2));
    assign RD_N     = !((state == T2) && !cmd_wr);
    assign WE_N     = ((state == T2) && cmd_wr) ? ~cmd_be : 2'b11;

endmodule

// File: doc/cs0_bus_master.md
Name: cs0_bus_master

Overview:
- Secondary bus master that borrows the CS0 system bus from the SH-2s through the EXBREQ_N/EXBACK_N arbitration pair and runs SH-2-style read/write cycles on it.
- Covers BIOS ROM, SMPC, backup SRAM, LWRAM and the MINIT/SINIT areas.
- It is the initiator counterpart to the CS0 address decoder and wait generator: it drives A/BS_N/CS0_N/RD_WR_N/RD_N/WE_N and obeys WAIT_N.
- Used by debug/save-state and cartridge-DMA logic through a simple REQ/ACK command port.

Parameters:
- TIMEOUT, 255, number of CE_R ticks WAIT_N may stay low before the cycle is aborted with ERR.
- HOLD_BUS, 1, when 1, back-to-back commands reuse the granted bus without releasing EXBREQ_N.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- CE_R  in  1  rising-phase clock enable; all state transitions occur here
- CE_F  in  1  falling-phase clock enable; WAIT_N and read data are sampled here
- RES_N  in  1  synchronous soft reset (system reset button)
- REQ  in  1  command valid
- REQ_WR  in  1  1 = write, 0 = read
- REQ_ADDR  in  24  word address, mapped to A[24:1]
- REQ_BE  in  2  byte enables; [1] = upper byte, [0] = lower byte
- REQ_WDATA  in  16  write data
- ACK  out  1  one-CLK pulse on command completion
- ERR  out  1  valid with ACK; 1 = timeout
- RDATA  out  16  read data, valid with ACK and held until the next ACK
- BUSY  out  1  high whenever the FSM is not IDLE
- EXBREQ_N  out  1  bus request to the arbiter
- EXBACK_N  in  1  bus grant from the arbiter
- A  out  24  bus address [24:1]
- BS_N  out  1  bus start strobe
- CS0_N  out  1  CS0 chip select
- RD_WR_N  out  1  cycle direction
- RD_N  out  1  read strobe
- WE_N  out  2  byte write strobes
- DI  in  16  bus read data
- DO  out  16  bus write data
- WAIT_N  in  1  wait request from the decoder/wait generator

Behaviour:
- Reset (RST_N low, or RES_N high-to-low sampled on CLK): FSM goes to IDLE. All strobes deassert: EXBREQ_N=1, BS_N=1, CS0_N=1, RD_N=1, WE_N=2'b11, RD_WR_N=1. A=0, DO=0, ACK=0, ERR=0, RDATA=0, BUSY=0, wait counter=0.
- RES_N low mid-cycle: the same values take effect on the next CLK, with no ACK. A command accepted before the reset is dropped.
- States, advancing only on CE_R unless stated otherwise:
  - IDLE: on REQ, latch the command and drive EXBREQ_N=0 -> ARB.
  - ARB: stay until EXBACK_N=0 -> T1.
  - T1: drive A and RD_WR_N (write -> 0); BS_N=0 and CS0_N=0 for exactly this tick; DO=REQ_WDATA on writes -> T2.
  - T2: BS_N=1 and CS0_N=0; RD_N=0 on reads; WE_N=~REQ_BE on writes. On each CE_F in T2, sample WAIT_N:
    - WAIT_N=1: set a done flag; at the next CE_R go to END. On reads, capture DI into RDATA on that same CE_F.
    - WAIT_N=0: increment the wait counter on each CE_R. When it reaches TIMEOUT -> END with ERR.
  - END: deassert RD_N, WE_N and CS0_N. Pulse ACK for one CLK with ERR. Then:
    - HOLD_BUS=1, REQ high and EXBACK_N=0: latch the new command -> T1.
    - Otherwise -> REL with EXBREQ_N=1.
  - REL: wait for EXBACK_N=1 -> IDLE.
- Minimum cycle length is 3 CE_R ticks (T1, T2, END) with zero waits.
- REQ_BE=2'b00 on a write: full bus cycle with WE_N=11, and ACK still pulses.
- REQ is level-sensitive and accepted only in IDLE or END. The requester holds the command stable until ACK.
- EXBACK_N rising while in T1/T2 (grant lost) is treated as an abort: -> END with ERR=1, and strobes released immediately.
- Wait counter is clog2(TIMEOUT+1) bits, saturating, and clears in T1.
- CE_R and CE_F both high in one CLK: the CE_F sample is evaluated first; the transition uses that sample.

Decomposition:
- Shared package holds:
  - FSM state enum {IDLE, ARB, T1, T2, END, REL}.
  - Address-window constants (ROM 0x000000, SMPC 0x100000, SRAM 0x180000, LWRAM 0x200000, MINIT 0x1000000, SINIT 0x1800000). The bench uses these; the block does not decode them.
- One sub-module, cs0_wait_timer: the saturating wait counter with timeout compare.

Test Plan:
- Read 0x200000 with arbiter granting 2 ticks after EXBREQ_N and WAIT_N held low 5 CE_R -> BS_N low 1 tick, RD_N low 6 ticks, RDATA = DI at the WAIT_N=1 CE_F, ACK=1, ERR=0, EXBREQ_N back to 1.
- Write 0x180000, BE=01, data 0xA55A, with WAIT_N always 1 -> WE_N=10 for one tick, DO=0xA55A, ACK after 3 CE_R from grant.
- Two queued reads with HOLD_BUS=1 -> EXBREQ_N stays 0 between them, second T1 immediately after the first END.
- WAIT_N stuck low with TIMEOUT=255 -> ACK with ERR=1 after 255 CE_R in T2, all strobes released.
- RES_N low during T2 -> next CLK all strobes high, no ACK, BUSY=0.
- EXBACK_N deasserted in T2 -> ERR=1 ACK, RD_N=1 the same tick.
